// File: rtl/width_gearbox_pkg.sv
// rtl/width_gearbox_pkg.sv - shared sizing helpers for the width_gearbox stream repacker
package width_gearbox_pkg;

    localparam int DEFAULT_IN_W    = 8;
    localparam int DEFAULT_OUT_W   = 12;
    localparam int DEFAULT_BUF_CAP = DEFAULT_IN_W + DEFAULT_OUT_W - 1;

    function automatic int cnt_width(input int in_w, input int out_w);
        return $clog2(in_w + out_w);
    endfunction

    function automatic int buf_cap(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

endpackage

// File: rtl/width_gearbox_if.sv
// rtl/width_gearbox_if.sv - input beat and output word handshake bundle for width_gearbox
interface width_gearbox_if
    import width_gearbox_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int OUT_W = DEFAULT_OUT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    // master: the producer/consumer pair around the gearbox
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/width_gearbox.sv
// rtl/width_gearbox.sv - IN_W to OUT_W MSB-first stream repacker; WIDTH_GEARBOX_FLUSH_EN adds end-of-packet flush
module width_gearbox
    import width_gearbox_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int OUT_W = DEFAULT_OUT_W
)(
    input  logic           clk,
    input  logic           rst_n,
    width_gearbox_if.slave bus
);

    localparam int BUF_W = buf_cap(IN_W, OUT_W);
    localparam int CW    = cnt_width(IN_W, OUT_W);
    localparam logic [CW-1:0] IN_W_C  = CW'(IN_W);
    localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);
    localparam logic [CW-1:0] BUF_W_C = CW'(BUF_W);

    logic [BUF_W-1:0] bit_buf, buf_next, comb_buf, beat_ext;
    logic [CW-1:0]    cnt, cnt_next, comb_cnt;
    logic             accept, slot_free, load;
    logic             out_valid_q, out_valid_next;
    logic [OUT_W-1:0] out_data_q, out_data_next;

`ifdef WIDTH_GEARBOX_FLUSH_EN
    logic flush_pending, flush_next, flush_act, load_last;
    logic out_last_q, out_last_next;

    assign flush_act     = flush_pending || (accept && bus.in_last);
    assign bus.in_ready  = (cnt < OUT_W_C) && !flush_pending;
    assign bus.out_last  = out_last_q;
`else
    logic unused_in_last;

    assign unused_in_last = bus.in_last;
    assign bus.in_ready   = (cnt < OUT_W_C);
    assign bus.out_last   = 1'b0;
`endif

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        // bits below cnt are always zero, so OR-ing the shifted beat appends it
        beat_ext                   = '0;
        beat_ext[BUF_W-1 -: IN_W]  = bus.in_data;
        comb_buf  = bit_buf | (accept ? (beat_ext >> cnt) : '0);
        comb_cnt  = cnt + (accept ? IN_W_C : '0);
        slot_free = !out_valid_q || bus.out_ready;

        load = 1'b0;
`ifdef WIDTH_GEARBOX_FLUSH_EN
        load_last = 1'b0;
        if (slot_free && flush_act && (comb_cnt != '0) && (comb_cnt <= OUT_W_C)) begin
            load      = 1'b1;
            load_last = 1'b1;
        end else if (slot_free && (comb_cnt >= OUT_W_C)) begin
            load = 1'b1;
        end
`else
        if (slot_free && (comb_cnt >= OUT_W_C))
            load = 1'b1;
`endif

        cnt_next       = comb_cnt;
        buf_next       = comb_buf;
        out_valid_next = out_valid_q && !bus.out_ready;
        out_data_next  = out_data_q;
`ifdef WIDTH_GEARBOX_FLUSH_EN
        out_last_next  = out_valid_next ? out_last_q : 1'b0;
        flush_next     = flush_act && !load_last;
`endif

        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = comb_buf[BUF_W-1 -: OUT_W];
            buf_next       = comb_buf << OUT_W;
            // a residual flush word empties the buffer completely
            cnt_next       = (comb_cnt >= OUT_W_C) ? (comb_cnt - OUT_W_C) : '0;
`ifdef WIDTH_GEARBOX_FLUSH_EN
            out_last_next  = load_last;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf       <= '0;
            cnt           <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
`ifdef WIDTH_GEARBOX_FLUSH_EN
            out_last_q    <= 1'b0;
            flush_pending <= 1'b0;
`endif
        end else begin
            bit_buf       <= buf_next;
            cnt           <= cnt_next;
            out_valid_q   <= out_valid_next;
            out_data_q    <= out_data_next;
`ifdef WIDTH_GEARBOX_FLUSH_EN
            out_last_q    <= out_last_next;
            flush_pending <= flush_next;
`endif
        end
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt <= BUF_W_C);

endmodule

// File: tb/tb_width_gearbox.sv
// tb/tb_width_gearbox.sv - scoreboard bench for width_gearbox at 8->12 and 12->8, flush tests under WIDTH_GEARBOX_FLUSH_EN
module tb_width_gearbox;
    import width_gearbox_pkg::*;

    localparam int TIMEOUT = 4 * DEFAULT_BUF_CAP;
`ifdef WIDTH_GEARBOX_FLUSH_EN
    localparam logic FLUSH = 1'b1;
`else
    localparam logic FLUSH = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    width_gearbox_if #(.IN_W(8),  .OUT_W(12)) ia ();
    width_gearbox_if #(.IN_W(12), .OUT_W(8))  ib ();

    width_gearbox #(.IN_W(8),  .OUT_W(12)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    width_gearbox #(.IN_W(12), .OUT_W(8))  u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int checks = 0;
    int errors = 0;
    logic [12:0] qa[$];
    logic [8:0]  qb[$];
    logic [12:0] ea;
    logic [8:0]  eb;
    int w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every accepted output word is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && ia.out_valid && ia.out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got word 0x%0h last %0b, expected none", ia.out_data, ia.out_last);
            end else begin
                ea = qa.pop_front();
                chk("a_word", 32'({ia.out_last, ia.out_data}), 32'(ea));
            end
        end
        if (rst_n && ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got word 0x%0h last %0b, expected none", ib.out_data, ib.out_last);
            end else begin
                eb = qb.pop_front();
                chk("b_word", 32'({ib.out_last, ib.out_data}), 32'(eb));
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input logic l, output int waits);
        int n = 0;
        ia.in_valid = 1'b1; ia.in_data = d; ia.in_last = l;
        @(negedge clk);
        while (!ia.in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!ia.in_ready) begin
            checks++; errors++;
            $display("FAIL a_send_timeout: in_ready 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.in_last = 1'b0;
        waits = n;
    endtask

    task automatic send_b(input logic [11:0] d, output int waits);
        int n = 0;
        ib.in_valid = 1'b1; ib.in_data = d; ib.in_last = 1'b0;
        @(negedge clk);
        while (!ib.in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!ib.in_ready) begin
            checks++; errors++;
            $display("FAIL b_send_timeout: in_ready 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        waits = n;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < TIMEOUT) begin @(negedge clk); n++; end
        chk(name, 32'(qa.size() + qb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_last = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_last = 1'b0; ib.out_ready = 1'b0;
        #2;
        chk("rst_a_in_ready",  32'(ia.in_ready),  32'd1);
        chk("rst_a_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_a_out_data",  32'(ia.out_data),  32'd0);
        chk("rst_a_out_last",  32'(ia.out_last),  32'd0);
        chk("rst_b_in_ready",  32'(ib.in_ready),  32'd1);
        chk("rst_b_out_valid", 32'(ib.out_valid), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // 8->12 back-to-back, last flag on the third beat
        ia.out_ready = 1'b1;
        qa.push_back({1'b0, 12'hA1B});
        qa.push_back({FLUSH, 12'h2C3});
        send_a(8'hA1, 1'b0, w); chk("t1_stall_a1", 32'(w), 32'd0);
        send_a(8'hB2, 1'b0, w); chk("t1_stall_b2", 32'(w), 32'd0);
        chk("t1_valid_after_b2", 32'(ia.out_valid), 32'd1);
        chk("t1_data_after_b2",  32'(ia.out_data),  32'hA1B);
        send_a(8'hC3, 1'b1, w); chk("t1_stall_c3", 32'(w), 32'd0);
        chk("t1_data_after_c3",  32'(ia.out_data),  32'h2C3);
        chk("t1_last_after_c3",  32'(ia.out_last),  32'(FLUSH));
        drain("t1_drain");

        // 8->12 with consumer stalled: three beats fit, fourth is held off
        ia.out_ready = 1'b0;
        qa.push_back({1'b0, 12'h112});
        qa.push_back({1'b0, 12'h233});
        qa.push_back({1'b0, 12'h445});
        qa.push_back({1'b0, 12'h566});
        send_a(8'h11, 1'b0, w);
        send_a(8'h22, 1'b0, w);
        send_a(8'h33, 1'b0, w); chk("t2_stall_33", 32'(w), 32'd0);
        ia.in_valid = 1'b1; ia.in_data = 8'h44;
        repeat (4) begin
            @(negedge clk);
            chk("t2_in_ready_held",  32'(ia.in_ready),  32'd0);
            chk("t2_out_valid_held", 32'(ia.out_valid), 32'd1);
            chk("t2_out_data_held",  32'(ia.out_data),  32'h112);
        end
        @(posedge clk); #1;
        ia.out_ready = 1'b1;
        send_a(8'h44, 1'b0, w);
        send_a(8'h55, 1'b0, w);
        send_a(8'h66, 1'b0, w);
        drain("t2_drain");

        // 12->8: each beat overfills, so input stalls while cnt >= 8
        ib.out_ready = 1'b1;
        qb.push_back({1'b0, 8'hAB});
        qb.push_back({1'b0, 8'hCD});
        qb.push_back({1'b0, 8'hEF});
        send_b(12'hABC, w); chk("t3_stall_abc", 32'(w), 32'd0);
        send_b(12'hDEF, w);
        chk("t3_in_ready_full", 32'(ib.in_ready), 32'd0);
        drain("t3_drain");
        chk("t3_in_ready_idle", 32'(ib.in_ready), 32'd1);

`ifdef WIDTH_GEARBOX_FLUSH_EN
        // single short packet flushes as a zero-padded word
        qa.push_back({1'b1, 12'hA10});
        send_a(8'hA1, 1'b1, w);
        chk("f1_out_valid", 32'(ia.out_valid), 32'd1);
        chk("f1_out_last",  32'(ia.out_last),  32'd1);
        drain("f1_drain");

        // full word drains first, residual follows with last; input held off meanwhile
        ia.out_ready = 1'b0;
        qa.push_back({1'b0, 12'h778});
        qa.push_back({1'b1, 12'h800});
        send_a(8'h77, 1'b0, w);
        send_a(8'h88, 1'b1, w);
        chk("f2_in_ready_pending", 32'(ia.in_ready), 32'd0);
        chk("f2_first_last",       32'(ia.out_last), 32'd0);
        ia.out_ready = 1'b1;
        drain("f2_drain");
        chk("f2_in_ready_after", 32'(ia.in_ready), 32'd1);
`endif

        // reset mid-operation discards buffered bits and the pending word
        ia.out_ready = 1'b0;
        send_a(8'h99, 1'b0, w);
        send_a(8'hAA, 1'b0, w);
        chk("r_pending_valid", 32'(ia.out_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("r_in_ready",  32'(ia.in_ready),  32'd1);
        chk("r_out_valid", 32'(ia.out_valid), 32'd0);
        chk("r_out_data",  32'(ia.out_data),  32'd0);
        chk("r_out_last",  32'(ia.out_last),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b1;
        qa.push_back({1'b0, 12'hD4E});
        qa.push_back({1'b0, 12'h5F6});
        send_a(8'hD4, 1'b0, w);
        send_a(8'hE5, 1'b0, w);
        chk("r_data_d4e", 32'(ia.out_data), 32'hD4E);
        send_a(8'hF6, 1'b0, w);
        drain("r_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_gearbox.md
# width_gearbox

Parametrised streaming width converter that repacks an IN_W-bit input stream into an OUT_W-bit output stream, MSB-first, with valid/ready flow control on both sides. It is the general form of the team's fixed 8-to-12 converters and sits between byte-oriented sources (UART/SPI deserialisers, FIFOs) and wider sample-oriented consumers. Optional end-of-packet flush emits a zero-padded partial word.

## Interface
- IN_W, default 8: input beat width in bits, ≥1.
- OUT_W, default 12: output word width in bits, ≥1; any ratio to IN_W is allowed.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN_W  input beat; bit IN_W-1 is sent first.
- in_last  input  1  beat is the final beat of a packet (flush feature only).
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  OUT_W  packed word; bit OUT_W-1 is the oldest bit.
- out_last  output  1  word is the final word of a packet.

## Operation
- Internal bit buffer of capacity IN_W+OUT_W-1 bits; fill count cnt ranges 0..IN_W+OUT_W-1. Valid bits are left-aligned, with the oldest bit at the MSB.
- Input handshake: a beat transfers when in_valid && in_ready. in_ready = (cnt < OUT_W) && !flush_pending. in_ready is registered-state only and has no combinational path from out_ready or in_valid.
- An accepted beat is appended directly below the existing valid bits; cnt += IN_W.
- Output slot: a single registered word. The slot is free when !out_valid || out_ready.
- Load rule: each cycle, form the combined view, which is the buffer plus the beat accepted this cycle. If combined count ≥ OUT_W and the slot is free, load the top OUT_W bits into out_data, set out_valid=1, shift the remainder up, and subtract OUT_W from cnt. At most one word loads per cycle.
- If the slot is freed (out_ready) and nothing loads, out_valid drops to 0.
- out_data holds its value while out_valid && !out_ready (AXI-style stability). out_valid never drops without a handshake.
- If IN_W < OUT_W, each input beat yields at most one word. If IN_W ≥ OUT_W, input stalls via in_ready until cnt falls below OUT_W.
- Throughput: sustained full rate with no bubbles when out_ready=1. For example, at 8→12, three beats produce two words, and cnt cycles 0→8→4→0.
- cnt width is $clog2(IN_W+OUT_W). Buffer arithmetic is unsigned with no overflow by construction. Simulation assertion: cnt never exceeds IN_W+OUT_W-1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, cnt=0, flush_pending=0, buffer=0.
- Latency: a word completed by the beat accepted at edge N is presented with out_valid=1 after edge N, provided the slot was free at that edge.
- Simultaneous output handshake and load in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Reset asserted mid-operation: buffered bits and any pending word are discarded immediately. There is no flush on reset.
- Deasserting in_valid between beats does not disturb buffered bits. Partial words are held indefinitely.

## Configuration
- Macro WIDTH_GEARBOX_FLUSH_EN.
- Defined: an accepted beat with in_last=1 sets flush_pending.
  - Full words drain normally.
  - Any residual bits (0 < cnt < OUT_W) are then emitted as one word, with data in the MSBs and zeros in the LSBs, and with out_last=1.
  - If the residual is 0, out_last=1 is set on the last full word produced from that beat.
  - flush_pending clears when the out_last word loads. in_ready is 0 while flush_pending=1.
- Undefined: in_last is ignored, out_last is tied to 0, and no flush logic or flush_pending register is present. Ports remain on the module in both builds.

## Structure
- Package width_gearbox_pkg: a function for the cnt width ($clog2(IN_W+OUT_W)) and a localparam for buffer capacity IN_W+OUT_W-1.
- No sub-module. The buffer, counter and output slot are tightly coupled, so the block is implemented as a single module.

## Test plan
- 8→12, out_ready=1, beats A1,B2,C3 back-to-back → words A1B then 2C3 on consecutive cycles after beats 2 and 3; in_ready stays 1.
- 8→12, out_ready=0 and 5 beats offered → in_ready drops once cnt ≥ 12; exactly 3 beats are accepted and out_data=A1B is held stable; on release the remaining words drain in order with no loss.
- 12→8, beats ABC,DEF → words AB,CD,EF; in_ready=0 while cnt ≥ 8.
- FLUSH_EN, 8→12, beat A1 with in_last → word A10 with out_last=1; in_ready=0 until it loads.
- FLUSH_EN, beats A1,B2,C3 with last on C3 → words A1B then 2C3, with out_last=1 on the second word only.
- rst_n pulsed low after one beat (8→12) → all outputs at reset values; the next beats D4,E5 yield D4E with no stale bits.
